// File: rtl/line_buffer_feeder_pkg.sv
// Shared types and defaults for the HEVC line-buffer feeder.
// Header layout: {ext_size, real_size}, real_size in the low field.
package hevc_lb_pkg;

  localparam int LB_DATA_W    = 18;
  localparam int LB_SIZE_W    = 7;
  localparam int HDR_REAL_LSB = 0;

  typedef enum logic {
    IDLE,
    STREAM
  } lb_state_t;

endpackage

// File: rtl/line_buffer_feeder_if.sv
// FIFO-side read and write interfaces, one strobe lane per flux.
// The actor modport faces the feeder; the fifo modport faces the storage.
interface read_interface #(
  parameter int FLUX = 2,
  parameter int W    = 8
);
  logic [FLUX-1:0][W-1:0] dout;
  logic [FLUX-1:0]        empty;
  logic [FLUX-1:0]        read;

  modport actor (input dout, input empty, output read);
  modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(
  parameter int FLUX = 2,
  parameter int W    = 8
);
  logic [W-1:0]    din;
  logic [FLUX-1:0] full;
  logic [FLUX-1:0] write;

  modport actor (output din, input full, output write);
  modport fifo  (input din, output full, input write);
endinterface

// File: rtl/line_buffer_feeder_rr.sv
// Round-robin arbiter: first requester strictly after ptr, wrapping.
// ptr is the last flux served.
module flux_rr_arbiter #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = $clog2(FLUX)
) (
  input  logic [FLUX-1:0]      req,
  input  logic [TAG_WIDTH-1:0] ptr,
  output logic                 grant_valid,
  output logic [TAG_WIDTH-1:0] grant_tag
);

  int idx;

  // scan far-to-near so the nearest requester after ptr wins
  always_comb begin
    grant_valid = 1'b0;
    grant_tag   = '0;
    idx         = 0;
    for (int k = FLUX; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= FLUX) idx = idx - FLUX;
      if (req[idx[TAG_WIDTH-1:0]]) begin
        grant_valid = 1'b1;
        grant_tag   = idx[TAG_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/line_buffer_feeder.sv
// Multi-flux feeder: per flux, a header yields two size tokens,
// then ext*real pels are forwarded, all tagged with the flux index.
module line_buffer_feeder
  import hevc_lb_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = LB_DATA_W,
  parameter int SIZE_WIDTH = LB_SIZE_W,
  parameter int TAG_WIDTH  = $clog2(FLUX)
) (
  input  logic         clk,
  input  logic         rst,
  read_interface.actor  read_port_in_hdr,
  read_interface.actor  read_port_in_pel,
  write_interface.actor write_port_ext_size,
  write_interface.actor write_port_real_size,
  write_interface.actor write_port_out_pel
);

  localparam int EXT_LSB = HDR_REAL_LSB + SIZE_WIDTH;

  typedef logic [SIZE_WIDTH-1:0] sz_t;

  lb_state_t state_q [FLUX];
  lb_state_t state_d [FLUX];
  sz_t       cnt_h_q [FLUX];
  sz_t       cnt_h_d [FLUX];
  sz_t       cnt_v_q [FLUX];
  sz_t       cnt_v_d [FLUX];
  sz_t       max_h_q [FLUX];
  sz_t       max_h_d [FLUX];
  sz_t       max_v_q [FLUX];
  sz_t       max_v_d [FLUX];

  logic [TAG_WIDTH-1:0]  rr_q;
  logic [TAG_WIDTH-1:0]  rr_d;
  logic [FLUX-1:0]       req;
  logic                  gnt_valid;
  logic [TAG_WIDTH-1:0]  gnt_tag;
  logic                  go;
  sz_t                   hdr_ext;
  sz_t                   hdr_rl;
  logic [DATA_WIDTH-1:0] pel;

  always_comb begin
    req = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (state_q[i] == IDLE)
        req[i] = !read_port_in_hdr.empty[i]
               & !write_port_ext_size.full[i]
               & !write_port_real_size.full[i];
      else
        req[i] = !read_port_in_pel.empty[i]
               & !write_port_out_pel.full[i];
    end
  end

  flux_rr_arbiter #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_arb (
    .req         (req),
    .ptr         (rr_q),
    .grant_valid (gnt_valid),
    .grant_tag   (gnt_tag)
  );

  assign go      = rst & gnt_valid;
  assign hdr_ext = read_port_in_hdr.dout[gnt_tag][EXT_LSB +: SIZE_WIDTH];
  assign hdr_rl  = read_port_in_hdr.dout[gnt_tag][HDR_REAL_LSB +: SIZE_WIDTH];
  assign pel     = read_port_in_pel.dout[gnt_tag][DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= TAG_WIDTH'(FLUX - 1);
      for (int i = 0; i < FLUX; i++) begin
        state_q[i] <= IDLE;
        cnt_h_q[i] <= '0;
        cnt_v_q[i] <= '0;
        max_h_q[i] <= '0;
        max_v_q[i] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      max_h_q <= max_h_d;
      max_v_q <= max_v_d;
    end
  end

  always_comb begin
    rr_d    = rr_q;
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    max_h_d = max_h_q;
    max_v_d = max_v_q;
    if (gnt_valid) begin
      rr_d = gnt_tag;
      unique case (state_q[gnt_tag])
        IDLE: begin
          max_h_d[gnt_tag] = hdr_rl;
          max_v_d[gnt_tag] = hdr_ext;
          cnt_h_d[gnt_tag] = '0;
          cnt_v_d[gnt_tag] = '0;
          // empty blocks still emit tokens but never stream
          if (hdr_ext == '0 || hdr_rl == '0)
            state_d[gnt_tag] = IDLE;
          else
            state_d[gnt_tag] = STREAM;
        end
        STREAM: begin
          if (cnt_h_q[gnt_tag] == max_h_q[gnt_tag] - sz_t'(1)) begin
            cnt_h_d[gnt_tag] = '0;
            if (cnt_v_q[gnt_tag] == max_v_q[gnt_tag] - sz_t'(1)) begin
              cnt_v_d[gnt_tag] = '0;
              state_d[gnt_tag] = IDLE;
            end else begin
              cnt_v_d[gnt_tag] = cnt_v_q[gnt_tag] + sz_t'(1);
            end
          end else begin
            cnt_h_d[gnt_tag] = cnt_h_q[gnt_tag] + sz_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    read_port_in_hdr.read      = '0;
    read_port_in_pel.read      = '0;
    write_port_ext_size.write  = '0;
    write_port_ext_size.din    = '0;
    write_port_real_size.write = '0;
    write_port_real_size.din   = '0;
    write_port_out_pel.write   = '0;
    write_port_out_pel.din     = '0;
    if (go) begin
      unique case (state_q[gnt_tag])
        IDLE: begin
          read_port_in_hdr.read[gnt_tag]      = 1'b1;
          write_port_ext_size.write[gnt_tag]  = 1'b1;
          write_port_real_size.write[gnt_tag] = 1'b1;
          write_port_ext_size.din             = {gnt_tag, hdr_ext};
          write_port_real_size.din            = {gnt_tag, hdr_rl};
        end
        STREAM: begin
          read_port_in_pel.read[gnt_tag]    = 1'b1;
          write_port_out_pel.write[gnt_tag] = 1'b1;
          write_port_out_pel.din            = {gnt_tag, pel};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Scoreboard bench for line_buffer_feeder with two fluxes.
// FIFO models feed the DUT; expected tokens are queued per flux.
module tb_line_buffer_feeder;

  localparam int FLUX = 2;
  localparam int DW   = 18;
  localparam int SW   = 7;
  localparam int TW   = 1;
  localparam int HW   = 2 * SW + TW;
  localparam int PW   = DW + TW;
  localparam int KW   = SW + TW;
  localparam int unsigned HDR_K = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  read_interface  #(.FLUX(FLUX), .W(HW)) hdr_if ();
  read_interface  #(.FLUX(FLUX), .W(PW)) pin_if ();
  write_interface #(.FLUX(FLUX), .W(KW)) ext_if ();
  write_interface #(.FLUX(FLUX), .W(KW)) rl_if ();
  write_interface #(.FLUX(FLUX), .W(PW)) pout_if ();

  line_buffer_feeder #(
    .FLUX       (FLUX),
    .DATA_WIDTH (DW),
    .SIZE_WIDTH (SW),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .read_port_in_hdr     (hdr_if),
    .read_port_in_pel     (pin_if),
    .write_port_ext_size  (ext_if),
    .write_port_real_size (rl_if),
    .write_port_out_pel   (pout_if)
  );

  logic [HW-1:0]   hdr_q [FLUX][$];
  logic [PW-1:0]   pel_q [FLUX][$];
  int unsigned     exp_q [FLUX][$];
  logic [FLUX-1:0] ext_full = '0;
  logic [FLUX-1:0] rl_full  = '0;
  logic [FLUX-1:0] out_full = '0;
  int n_chk  = 0;
  int n_pass = 0;
  bit alt_on = 1'b0;

  task automatic check_eq(string tag, int unsigned got, int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int unsigned hdr_tok(int unsigned e, int unsigned r);
    return HDR_K | (e << 8) | r;
  endfunction

  function automatic logic [9:0] strobes();
    return {hdr_if.read, pin_if.read, ext_if.write,
            rl_if.write, pout_if.write};
  endfunction

  task automatic push_blk(int f, int e, int r, int base);
    hdr_q[f].push_back({TW'($urandom), SW'(e), SW'(r)});
    exp_q[f].push_back(hdr_tok(e, r));
    for (int n = 0; n < e * r; n++) begin
      pel_q[f].push_back({TW'($urandom), DW'(base + n)});
      exp_q[f].push_back(unsigned'(base + n));
    end
  endtask

  task automatic pop_exp(int f, string tag, int unsigned got);
    int unsigned e;
    if (exp_q[f].size() == 0) begin
      check_eq({tag, "_unexpected"}, exp_q[f].size(), 1);
    end else begin
      e = exp_q[f].pop_front();
      check_eq(tag, got, e);
    end
  endtask

  task automatic wait_drain(int f, int target, int budget);
    int n = 0;
    while (exp_q[f].size() > target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_level", exp_q[f].size(), target);
  endtask

  // FIFO model outputs settle 2 time units after each rising edge
  initial forever begin
    for (int f = 0; f < FLUX; f++) begin
      hdr_if.empty[f] = (hdr_q[f].size() == 0);
      pin_if.empty[f] = (pel_q[f].size() == 0);
      if (hdr_q[f].size() != 0) hdr_if.dout[f] = hdr_q[f][0];
      else hdr_if.dout[f] = '0;
      if (pel_q[f].size() != 0) pin_if.dout[f] = pel_q[f][0];
      else pin_if.dout[f] = '0;
    end
    ext_if.full  = ext_full;
    rl_if.full   = rl_full;
    pout_if.full = out_full;
    @(posedge clk); #2;
  end

  initial begin
    logic [FLUX-1:0] hrd;
    logic [FLUX-1:0] prd;
    int any;
    int tag;
    bit prev_any = 1'b0;
    int prev_tag = 0;
    forever begin
      @(negedge clk);
      hrd = hdr_if.read;
      prd = pin_if.read;
      any = 0;
      tag = 0;
      for (int f = 0; f < FLUX; f++) begin
        if (ext_if.write[f] || rl_if.write[f]) begin
          check_eq("hdr_atomic",
                   {hdr_if.read[f], ext_if.write[f], rl_if.write[f]}, 3'b111);
          check_eq("ext_tag", ext_if.din[SW], f);
          check_eq("real_tag", rl_if.din[SW], f);
          pop_exp(f, "hdr_tok", hdr_tok(ext_if.din[SW-1:0], rl_if.din[SW-1:0]));
          any++;
          tag = f;
        end
        if (pin_if.read[f] || pout_if.write[f]) begin
          check_eq("pel_pair", {pin_if.read[f], pout_if.write[f]}, 2'b11);
          check_eq("pel_tag", pout_if.din[DW], f);
          pop_exp(f, "pel", pout_if.din[DW-1:0]);
          any++;
          tag = f;
        end
      end
      if (any > 0) check_eq("one_grant", any, 1);
      if (alt_on && any > 0 && prev_any) check_eq("alternate", tag, 1 - prev_tag);
      prev_any = (any > 0);
      prev_tag = tag;
      @(posedge clk);
      for (int f = 0; f < FLUX; f++) begin
        if (hrd[f]) begin
          if (hdr_q[f].size() != 0) void'(hdr_q[f].pop_front());
          else check_eq("hdr_underflow", hdr_q[f].size(), 1);
        end
        if (prd[f]) begin
          if (pel_q[f].size() != 0) void'(pel_q[f].pop_front());
          else check_eq("pel_underflow", pel_q[f].size(), 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset holds strobes low even with a header waiting
    push_blk(0, 3, 4, 1);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_strobes", strobes(), 0);
      check_eq("rst_din", {ext_if.din, rl_if.din, pout_if.din}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    wait_drain(0, 0, 100);

    // zero-area block then a 1x1 block on flux 1
    push_blk(1, 0, 5, 0);
    push_blk(1, 1, 1, 'h77);
    wait_drain(1, 0, 50);

    // both fluxes streaming must alternate
    @(posedge clk); #1;
    alt_on = 1'b1;
    push_blk(0, 2, 4, 200);
    push_blk(1, 2, 4, 300);
    wait_drain(0, 0, 100);
    wait_drain(1, 0, 100);
    alt_on = 1'b0;

    // out_pel stall on flux 0 mid-line
    push_blk(0, 2, 6, 400);
    push_blk(1, 3, 8, 500);
    wait_drain(0, 8, 100);
    out_full[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_rd0", pin_if.read[0], 0);
      check_eq("stall_wr0", pout_if.write[0], 0);
      check_eq("serve_f1", pout_if.write[1], 1);
    end
    @(posedge clk); #1;
    out_full[0] = 1'b0;
    wait_drain(0, 0, 100);
    wait_drain(1, 0, 100);

    // real_size full blocks the whole header action
    @(posedge clk); #1;
    rl_full[0] = 1'b1;
    push_blk(0, 2, 1, 600);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("full_hdr_rd", hdr_if.read[0], 0);
      check_eq("full_ext_wr", ext_if.write[0], 0);
    end
    @(posedge clk); #1;
    rl_full[0] = 1'b0;
    @(negedge clk);
    check_eq("rel_ext_wr", ext_if.write[0], 1);
    check_eq("rel_real_wr", rl_if.write[0], 1);
    wait_drain(0, 0, 50);

    // reset in the middle of a 1x127 block
    push_blk(0, 1, 127, 1000);
    wait_drain(0, 67, 300);
    rst = 1'b0;
    #1;
    check_eq("rst_drop", strobes(), 0);
    repeat (3) @(posedge clk);
    #1;
    exp_q[0].delete();
    hdr_q[0].push_back({TW'(1), SW'(2), SW'(2)});
    exp_q[0].push_back(hdr_tok(2, 2));
    for (int n = 0; n < 4; n++) exp_q[0].push_back(pel_q[0][n][DW-1:0]);
    rst = 1'b1;
    wait_drain(0, 0, 50);
    repeat (4) @(posedge clk);
    #1;
    check_eq("post_rst_left", pel_q[0].size(), 127 - 60 - 4);
    check_eq("hdr_left0", hdr_q[0].size(), 0);
    check_eq("hdr_left1", hdr_q[1].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
